// File: rtl/shift_pkg.sv
// Shared types and constants for the serdes shift register.
// Operation encoding and the default register length.
package shift_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHL  = 2'b01,
    SHR  = 2'b10,
    LOAD = 2'b11
  } shift_mode_t;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/shift_frame_counter.sv
// Frame counter: counts executed shifts modulo WIDTH and flags the wrapping shift.
// clr takes priority over inc.
module shift_frame_counter #(
  parameter int WIDTH = 16,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Combinational so the owner can register it as a one-cycle pulse.
  assign wrap = inc && !clr && (count == LAST);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/serdes_shift_register.sv
// Shift register with hold/shift-left/shift-right/load, frame counting and frame pulse.
// Optional rotate input enabled by macro SHIFT_REG_ROTATE_EN.
module serdes_shift_register
  import shift_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic [1:0]               mode_i,
  input  logic                     in_i,
  input  logic [WIDTH-1:0]         par_i,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic                     rot_i,
`endif
  output logic [WIDTH-1:0]         out_o,
  output logic                     ser_o,
  output logic [$clog2(WIDTH)-1:0] count_o,
  output logic                     frame_o
);

  shift_mode_t      mode;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic             shl_in;
  logic             shr_in;
  logic             shift_en;
  logic             load_en;
  logic             wrap;

  assign mode = shift_mode_t'(mode_i);

`ifdef SHIFT_REG_ROTATE_EN
  // Rotation feeds back the bit that is leaving in the active direction.
  assign shl_in = rot_i ? sreg[WIDTH-1] : in_i;
  assign shr_in = rot_i ? sreg[0]       : in_i;
`else
  assign shl_in = in_i;
  assign shr_in = in_i;
`endif

  assign shift_en = en_i && ((mode == SHL) || (mode == SHR));
  assign load_en  = en_i && (mode == LOAD);

  always_comb begin
    sreg_nxt = sreg;
    if (clr_i) begin
      sreg_nxt = RESET_VAL;
    end else if (en_i) begin
      unique case (mode)
        HOLD: sreg_nxt = sreg;
        SHL:  sreg_nxt = {sreg[WIDTH-2:0], shl_in};
        SHR:  sreg_nxt = {shr_in, sreg[WIDTH-1:1]};
        LOAD: sreg_nxt = par_i;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sreg <= RESET_VAL;
    end else begin
      sreg <= sreg_nxt;
    end
  end

  shift_frame_counter #(.WIDTH(WIDTH)) u_frame_counter (
    .clk    (clk),
    .resetb (resetb),
    .inc    (shift_en && !clr_i),
    .clr    (clr_i || load_en),
    .count  (count_o),
    .wrap   (wrap)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      frame_o <= 1'b0;
    end else if (clr_i) begin
      frame_o <= 1'b0;
    end else begin
      frame_o <= wrap;
    end
  end

  assign out_o = sreg;
  // The serial tap follows the requested direction even while not shifting.
  assign ser_o = (mode == SHR) ? sreg[0] : sreg[WIDTH-1];

endmodule

// File: doc/serdes_shift_register.md
SERDES_SHIFT_REGISTER -- requirements
Module: serdes_shift_register

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register length in bits (legal range 2..64).
REQ-002 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded on reset and on clr_i.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetb  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port clr_i  input  1  synchronous clear.
REQ-006 SHALL have port en_i  input  1  enable for shift and load operations.
REQ-007 SHALL have port mode_i  input  2  operation: 00 hold, 01 shift-left, 10 shift-right, 11 parallel load.
REQ-008 SHALL have port in_i  input  1  serial input bit.
REQ-009 SHALL have port par_i  input  WIDTH  parallel load data.
REQ-010 SHALL have port rot_i  input  1  rotate select; present only with SHIFT_REG_ROTATE_EN.
REQ-011 SHALL have port out_o  output  WIDTH  register contents.
REQ-012 SHALL have port ser_o  output  1  serial output bit.
REQ-013 SHALL have port count_o  output  $clog2(WIDTH)  shifts since last load/clear, modulo WIDTH.
REQ-014 SHALL have port frame_o  output  1  one-cycle pulse on frame completion.

Function
REQ-015 Priority per edge SHALL be: clr_i, then en_i with mode_i; en_i low or mode 00 holds register and counter.
REQ-016 Shift-left SHALL set reg <= {reg[WIDTH-2:0], in_i}; the bit leaving is reg[WIDTH-1].
REQ-017 Shift-right SHALL set reg <= {in_i, reg[WIDTH-1:1]}; the bit leaving is reg[0].
REQ-018 Parallel load SHALL set reg <= par_i and count to 0, with no frame_o pulse.
REQ-019 ser_o SHALL be combinational: reg[0] when mode_i = 10, otherwise reg[WIDTH-1].
REQ-020 Each executed shift SHALL increment count by 1; at WIDTH-1 it SHALL wrap to 0.
REQ-021 frame_o SHALL be registered and high exactly the cycle after the shift that wraps count to 0.
REQ-022 Back-to-back frames SHALL give pulses exactly WIDTH enabled shifts apart, with no gap cycle.
REQ-023 clr_i SHALL set reg to RESET_VAL, count to 0 and frame_o to 0, regardless of en_i and mode_i.
REQ-024 A direction change mid-frame SHALL NOT reset count.
REQ-025 out_o SHALL equal the internal register with zero latency.

Reset
REQ-026 While resetb is low: out_o = RESET_VAL, count_o = 0, frame_o = 0, regardless of clk.
REQ-027 Reset assertion mid-frame SHALL abort the frame; no frame_o pulse SHALL follow deassertion.
REQ-028 The first edge after resetb rises SHALL be a normal operating edge.

Configuration
REQ-029 Macro SHIFT_REG_ROTATE_EN defined: when rot_i = 1, the shift input SHALL be the bit leaving, not in_i. This applies to both shift directions, and counting is unchanged.
REQ-030 Macro SHIFT_REG_ROTATE_EN undefined: rot_i SHALL be absent, and shifts SHALL always take in_i.

Structure
REQ-031 Package shift_pkg SHALL hold the mode typedef (enum HOLD, SHL, SHR, LOAD) and the default WIDTH constant.
REQ-032 The frame counter SHALL be a sub-module, shift_frame_counter, with inputs inc and clr and outputs count and wrap.
REQ-033 Implementation size SHALL be 120-400 RTL lines.

Verification
REQ-034 Reset with WIDTH=16: apply 16 shift-left cycles of in_i=1 and release mid-frame. Required: out_o=0000, count_o=0, no frame_o.
REQ-035 Load par_i=A5C3, then 16 shift-right cycles with in_i=0. Required: ser_o streams 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; out_o ends 0000; frame_o is high the next cycle only.
REQ-036 32 consecutive shift-left cycles with en_i toggled off for 3 cycles at shift 10. Required: frame_o pulses after shift 16 and shift 32 only; count_o holds at 10 during the stall.
REQ-037 clr_i and mode LOAD in the same cycle with en_i=1. Required: out_o=RESET_VAL and count_o=0.
REQ-038 With SHIFT_REG_ROTATE_EN: load 8001, then rot_i=1 for 1 shift-left. Required: out_o=0003. After 16 rotates from the load, out_o returns to 8001 and frame_o pulses.
REQ-039 Load mid-frame at count_o=7. Required: count_o=0 next cycle, no frame_o pulse, and the next frame_o arrives 16 shifts later.
